mont_encode: RTL and testbench

- Pipelined converter from the normal domain into the Montgomery domain for Dilithium coefficients (Q = 8380417, R = 2^32).
- Computes a*R mod Q as MontgomeryReduce(a * R2), where R2 = 2^64 mod Q = 2365951.
- Sits ahead of the NTT/butterfly datapath, so coefficients enter Montgomery form before multiplication. The existing Montgomery reduction performs the exit direction.
- Streams one coefficient per cycle with valid/ready backpressure.

---
 rtl/mont_pkg.sv | 13 +
 rtl/mont_reduce_comb.sv | 24 ++
 rtl/mont_encode.sv | 75 +++++++
 tb/tb_mont_encode.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mont_pkg.sv
// Shared constants and coefficient types for the Dilithium Montgomery-domain datapath.
// Q = 8380417, R = 2^32.
package mont_pkg;

  typedef logic signed [31:0] coeff_t;
  typedef logic signed [63:0] dcoeff_t;

  localparam coeff_t Q       = 32'sd8380417;
  localparam coeff_t QINV    = 32'sd58728449;
  localparam coeff_t MONT_R  = 32'sd4193792;
  localparam coeff_t MONT_R2 = 32'sd2365951;

endpackage

// File: rtl/mont_reduce_comb.sv
// Combinational Montgomery reduction x * 2^-32 mod Q, split at the t register so a caller
// may pipeline between the t computation and the final subtract/shift/correct.
module mont_reduce_comb
  import mont_pkg::*;
(
  input  logic signed [31:0] p_lo_i,
  output logic signed [31:0] t_o,
  input  logic signed [63:0] p_i,
  input  logic signed [31:0] t_i,
  output logic signed [31:0] r_o
);

  // |p| < Q*2^31 keeps the shifted value inside (-Q, Q), so one conditional add suffices.
  function automatic coeff_t add_q_if_neg(input coeff_t v);
    return (v < 0) ? v + Q : v;
  endfunction

  dcoeff_t diff;

  assign t_o  = coeff_t'(p_lo_i * QINV);
  assign diff = p_i - dcoeff_t'(t_i) * dcoeff_t'(Q);
  assign r_o  = add_q_if_neg(coeff_t'(diff >>> 32));

endmodule

// File: rtl/mont_encode.sv
// Streams int32 coefficients into the Montgomery domain: A_o = A_i * 2^32 mod Q in [0, Q).
// Input register plus three arithmetic stages, all gated by one global enable.
module mont_encode
  import mont_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic signed [31:0] A_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic signed [31:0] A_o
);

  logic    en;
  coeff_t  a_p0;
  logic    vld_p0;
  dcoeff_t p_p1;
  logic    vld_p1;
  dcoeff_t p_p2;
  coeff_t  t_p2;
  logic    vld_p2;
  coeff_t  p1_lo;
  coeff_t  t_nxt;
  coeff_t  r_nxt;

  assign en         = !out_valid_o || out_ready_i;
  assign in_ready_o = en;
  assign p1_lo      = p_p1[31:0];

  mont_reduce_comb u_reduce (
    .p_lo_i (p1_lo),
    .t_o    (t_nxt),
    .p_i    (p_p2),
    .t_i    (t_p2),
    .r_o    (r_nxt)
  );

  always_ff @(posedge clk_i) begin
    if (en) begin
      // p0: capture accepted coefficient
      a_p0 <= A_i;
      // p1: scale by R^2 mod Q
      p_p1 <= dcoeff_t'(a_p0) * dcoeff_t'(MONT_R2);
      // p2: Montgomery quotient t, carry p
      p_p2 <= p_p1;
      t_p2 <= t_nxt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p0      <= 1'b0;
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
      out_valid_o <= 1'b0;
      A_o         <= '0;
    end else if (flush_i) begin
      vld_p0      <= 1'b0;
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
      out_valid_o <= 1'b0;
    end else if (en) begin
      vld_p0      <= in_valid_i;
      vld_p1      <= vld_p0;
      vld_p2      <= vld_p1;
      out_valid_o <= vld_p2;
      // output stage: reduced, corrected result
      if (vld_p2) A_o <= r_nxt;
    end
  end

endmodule

// File: tb/tb_mont_encode.sv
// Scoreboard bench for mont_encode: driver pushes golden (a*2^32 mod Q) on every accepted
// input, monitor pops and compares on every output transfer.
module tb_mont_encode;

  localparam longint Q_L = 64'd8380417;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               flush = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [31:0] a_in = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [31:0] a_out;

  int checks = 0;
  int errors = 0;
  int n_in = 0;
  int n_out = 0;
  longint sb[$];

  mont_encode dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .A_i         (a_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .A_o         (a_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic longint model(input logic signed [31:0] a);
    longint r;
    r = longint'(a) % Q_L;
    if (r < 0) r = r + Q_L;
    return (r * (longint'(1) <<< 32)) % Q_L;
  endfunction

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, expv);
    end
  endtask

  // Monitor: inputs change 1ns after posedge, so negedge values are what the next edge sees.
  logic               hold_prev = 1'b0;
  logic signed [31:0] held = '0;
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev && out_valid) begin
        checks++;
        if (a_out !== held) begin
          errors++;
          $display("FAIL stall_hold got %0d expected %0d", a_out, held);
        end
      end
      if (out_valid && out_ready && !flush) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output got %0d expected none", a_out);
        end else begin
          longint e;
          e = sb.pop_front();
          n_out++;
          checks++;
          if (longint'(a_out) != e) begin
            errors++;
            $display("FAIL result got %0d expected %0d", a_out, e);
          end
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) begin
        sb.push_back(model(a_in));
        n_in++;
      end
      hold_prev = out_valid && !out_ready && !flush;
      held = a_out;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send(input logic signed [31:0] a);
    int n;
    bit acc;
    n = 0;
    in_valid = 1'b1;
    a_in = a;
    do begin
      #1;
      acc = in_ready;
      tick();
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic check_latency(input logic signed [31:0] a, input longint expv);
    out_ready = 1'b1;
    send(a);
    in_valid = 1'b0;
    tick();
    tick();
    chk("lat_not_early", longint'(out_valid), 0);
    tick();
    chk("lat_valid_k3", longint'(out_valid), 1);
    chk("lat_value", longint'(a_out), expv);
    idle(3);
  endtask

  initial begin
    int n;
    bit acc;
    int idx;
    int base_in, base_out;
    logic signed [31:0] vals [4];
    logic signed [31:0] a_before;

    repeat (2) tick();
    chk("reset_out_valid", longint'(out_valid), 0);
    chk("reset_a_o", longint'(a_out), 0);
    chk("reset_in_ready", longint'(in_ready), 1);
    rst = 1'b0;
    tick();

    check_latency(32'sd1, 64'd4193792);

    // back-to-back stream
    send(32'sd0);
    send(-32'sd1);
    send(32'sd8380417);
    send(32'sd2);
    idle(8);

    // int32 extremes
    send(32'sh7fffffff);
    send(32'sh80000000);
    idle(8);

    // downstream stall with four offers
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) vals[i] = $urandom;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (idx < 4);
      a_in = vals[idx < 4 ? idx : 3];
      #1;
      acc = in_valid && in_ready;
      tick();
      if (acc) idx++;
    end
    chk("stall_accepted", idx, 4);
    chk("stall_in_ready_low", longint'(in_ready), 0);
    chk("stall_out_valid", longint'(out_valid), 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(8);
    chk("stall_drained", sb.size(), 0);

    // asynchronous reset with three in flight
    send($urandom);
    send($urandom);
    send($urandom);
    in_valid = 1'b0;
    #3;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("async_rst_valid", longint'(out_valid), 0);
    chk("async_rst_a_o", longint'(a_out), 0);
    tick();
    rst = 1'b0;
    idle(8);
    chk("post_rst_quiet", longint'(out_valid), 0);

    // flush with full pipeline and input offered
    out_ready = 1'b0;
    in_valid = 1'b1;
    n = 0;
    do begin
      a_in = $urandom;
      #1;
      acc = in_ready;
      tick();
      n++;
    end while (acc && n < 20);
    chk("flush_fill_full", longint'(in_ready), 0);
    a_before = a_out;
    flush = 1'b1;
    a_in = $urandom;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_clears_valid", longint'(out_valid), 0);
    chk("flush_keeps_a_o", longint'(a_out), longint'(a_before));
    out_ready = 1'b1;
    idle(6);
    check_latency(32'sd1, 64'd4193792);

    // randomized traffic with random backpressure
    idle(4);
    base_in = n_in;
    base_out = n_out;
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(3, 0) != 0);
      a_in = $urandom;
      out_ready = ($urandom_range(3, 0) != 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(10);
    chk("random_sb_empty", sb.size(), 0);
    chk("random_count", n_out - base_out, n_in - base_in);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
